// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared FSM encodings and sizing helpers for the FIFO read packer
package fifo_rd_pkg;

  typedef logic [1:0] fsm_t;

  localparam fsm_t RUN        = 2'd0;
  localparam fsm_t FLUSH_WAIT = 2'd1;
  localparam fsm_t FLUSH_EMIT = 2'd2;

  // Lane counter must represent 0..PACK inclusive.
  function automatic int lane_cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/stream_beat_reg.sv
// rtl/stream_beat_reg.sv - output beat register with valid/ready hold and load enable
module stream_beat_reg #(
  parameter int WIDTH = 32,
  parameter int KEEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [KEEP-1:0]  load_keep,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [KEEP-1:0]  keep,
  output logic             last
);

  // The caller only asserts load when the register is free, so load wins outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops a FIFO read port and packs PACK words per output beat, with flush
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       rd_clk,
  input  logic                       rst_n,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                       fifo_empty,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       flush_done,
  output logic [CNT_WIDTH-1:0]       word_count
);

  localparam int LW = lane_cnt_width(PACK);

  fsm_t                  state;
  logic [LW-1:0]         lane_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] acc [PACK];

  logic [LW-1:0]              lane_eff;
  logic                       out_free;
  logic                       load_full;
  logic                       emit_partial;
  logic                       beat_load;
  logic [DATA_WIDTH*PACK-1:0] load_data;
  logic [PACK-1:0]            load_keep;

  // lane_eff counts the word landing this cycle so a completed beat loads on its capture edge.
  assign lane_eff     = lane_cnt + LW'(inflight);
  assign out_free     = !m_valid || m_ready;
  assign load_full    = (lane_eff == LW'(PACK)) && out_free;
  assign emit_partial = (state == FLUSH_EMIT) && (lane_cnt != '0) && out_free;
  assign beat_load    = load_full || emit_partial;
  assign flush_done   = (state == FLUSH_EMIT) && ((lane_cnt == '0) || out_free);

  assign fifo_rd_en = rst_n && (state == RUN) && !flush && !fifo_empty
                      && (int'(lane_eff) < PACK);

  always_comb begin
    load_data = '0;
    load_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (int'(lane_eff) > i) begin
        load_keep[i] = 1'b1;
        load_data[i*DATA_WIDTH +: DATA_WIDTH] =
          (inflight && int'(lane_cnt) == i) ? fifo_rd_data : acc[i];
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state      <= RUN;
      lane_cnt   <= '0;
      inflight   <= 1'b0;
      word_count <= '0;
      for (int i = 0; i < PACK; i++) acc[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        word_count <= word_count + 1'b1;
        for (int i = 0; i < PACK; i++) begin
          if (int'(lane_cnt) == i) acc[i] <= fifo_rd_data;
        end
      end
      lane_cnt <= beat_load ? '0 : lane_eff;

      case (state)
        RUN:        if (flush) state <= FLUSH_WAIT;
        FLUSH_WAIT: if (!inflight && lane_cnt != LW'(PACK)) state <= FLUSH_EMIT;
        FLUSH_EMIT: if (flush_done) state <= RUN;
        default:    state <= RUN;
      endcase
    end
  end

  stream_beat_reg #(
    .WIDTH(DATA_WIDTH*PACK),
    .KEEP (PACK)
  ) u_out (
    .clk      (rd_clk),
    .rst_n    (rst_n),
    .load     (beat_load),
    .load_data(load_data),
    .load_keep(load_keep),
    .load_last(emit_partial),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .keep     (m_keep),
    .last     (m_last)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer with a FIFO read model
module tb_fifo_rd_packer;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = '0;
  logic        fifo_empty;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        flush_done;
  logic [15:0] word_count;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4), .CNT_WIDTH(16)) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .flush       (flush),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .flush_done  (flush_done),
    .word_count  (word_count)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read side: one-cycle read latency
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  int cyc = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  int pops = 0;
  int first_pop = -1;
  int dones = 0;
  int fd_cyc = -1;
  int fl_cyc = -1;
  logic [31:0] bd [$];
  logic [3:0]  bk [$];
  logic        bl [$];
  int          bc [$];

  always @(negedge rd_clk) begin
    if (fifo_rd_en) begin
      if (first_pop < 0) first_pop = cyc;
      pops++;
    end
    if (m_valid && m_ready) begin
      bd.push_back(m_data);
      bk.push_back(m_keep);
      bl.push_back(m_last);
      bc.push_back(cyc);
    end
    if (flush_done) begin
      dones++;
      fd_cyc = cyc;
    end
    if (flush) fl_cyc = cyc;
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int limit);
    for (int i = 0; i < limit && bd.size() < n; i++) tick(1);
  endtask

  task automatic wait_dones(input int n, input int limit);
    for (int i = 0; i < limit && dones < n; i++) tick(1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  int nb;
  int nd;
  int snap;

  initial begin
    // reset with data already queued: no pops may leak out
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(3);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_keep", m_keep, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_done", flush_done, 0);
    check_eq("rst_count", word_count, 0);

    rst_n = 1'b1;
    wait_beats(2, 40);
    check_eq("b0_n", bd.size(), 2);
    check_eq("b0_data", bd[0], 32'h04030201);
    check_eq("b0_keep", bk[0], 4'hF);
    check_eq("b0_last", bl[0], 0);
    check_eq("b1_data", bd[1], 32'h08070605);
    check_eq("b1_keep", bk[1], 4'hF);
    check_eq("b0_lat", bc[0] - first_pop, 5);
    check_eq("b1_gap", bc[1] - bc[0], 5);
    tick(2);
    check_eq("count8", word_count, 8);

    // backpressure: one held beat plus one full accumulator
    m_ready = 1'b0;
    snap = pops;
    nb = bd.size();
    for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
    tick(20);
    check_eq("bp_pops", pops - snap, 8);
    check_eq("bp_rd_en", fifo_rd_en, 0);
    check_eq("bp_valid", m_valid, 1);
    check_eq("bp_hold", m_data, 32'h13121110);
    m_ready = 1'b1;
    wait_beats(nb + 3, 60);
    tick(10);
    check_eq("bp_n", bd.size() - nb, 3);
    check_eq("bp_b0", bd[nb], 32'h13121110);
    check_eq("bp_b1", bd[nb+1], 32'h17161514);
    check_eq("bp_b2", bd[nb+2], 32'h1B1A1918);
    check_eq("count20", word_count, 20);

    // partial flush
    nb = bd.size();
    nd = dones;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(10);
    pulse_flush();
    wait_dones(nd + 1, 20);
    tick(4);
    check_eq("pf_done", dones - nd, 1);
    check_eq("pf_n", bd.size() - nb, 1);
    check_eq("pf_data", bd[nb], 32'h00A3A2A1);
    check_eq("pf_keep", bk[nb], 4'b0111);
    check_eq("pf_last", bl[nb], 1);

    // empty flush: no beat, done two cycles after the request
    nb = bd.size();
    nd = dones;
    pulse_flush();
    wait_dones(nd + 1, 20);
    tick(4);
    check_eq("ef_done", dones - nd, 1);
    check_eq("ef_lat", fd_cyc - fl_cyc, 2);
    check_eq("ef_nobeat", bd.size() - nb, 0);

    // flush arriving the cycle after a pop
    nb = bd.size();
    nd = dones;
    snap = pops;
    push(8'hC1); push(8'hC2); push(8'hC3);
    for (int i = 0; i < 20 && pops == snap; i++) tick(1);
    snap = pops;
    pulse_flush();
    wait_dones(nd + 1, 20);
    check_eq("rf_nopop", pops - snap, 0);
    tick(4);
    check_eq("rf_n", bd.size() - nb, 1);
    check_eq("rf_data", bd[nb], 32'h000000C1);
    check_eq("rf_keep", bk[nb], 4'b0001);
    check_eq("rf_last", bl[nb], 1);
    tick(6);
    pulse_flush();
    wait_dones(nd + 2, 20);
    tick(4);
    check_eq("rf2_n", bd.size() - nb, 2);
    check_eq("rf2_data", bd[nb+1], 32'h0000C3C2);
    check_eq("rf2_keep", bk[nb+1], 4'b0011);

    // reset mid-beat
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'hD0 + 8'(i));
    tick(15);
    check_eq("mr_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    tick(1);
    check_eq("mr_valid", m_valid, 0);
    check_eq("mr_count", word_count, 0);
    check_eq("mr_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    nb = bd.size();
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    wait_beats(nb + 1, 30);
    tick(3);
    check_eq("mr_n", bd.size() - nb, 1);
    check_eq("mr_data", bd[nb], 32'hE4E3E2E1);
    check_eq("mr_keep", bk[nb], 4'hF);
    check_eq("mr_count4", word_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
